// File: rtl/keypad_matrix_emulator.sv
// Keypad-side model of a 4x4 membrane matrix: presses one key per request with
// programmable contact bounce, hold and release gap, driving active-low rows.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for a request, contact open, key_ready high
// BOUNCE_IN  | contact chatters on press, starting closed
// HOLD       | contact solidly closed
// BOUNCE_OUT | contact chatters on release, starting open
// GAP        | contact open; done pulses when this phase ends
module keypad_matrix_emulator #(
   parameter int HOLD_CYCLES   = 200000,
   parameter int BOUNCE_CYCLES = 2000,
   parameter int BOUNCE_PERIOD = 100,
   parameter int GAP_CYCLES    = 50000,
   parameter int CNT_W         = 24
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic [3:0] columnas,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic       abort,
   output logic [3:0] filas,
   output logic       busy,
   output logic       done
);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(BOUNCE_PERIOD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
   localparam bit               NO_BOUNCE   = (BOUNCE_CYCLES == 0);

   typedef enum logic [2:0] {
      IDLE,
      BOUNCE_IN,
      HOLD,
      BOUNCE_OUT,
      GAP
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] pcnt;
   logic             bphase;
   logic [3:0]       key_q;
   logic             contact;
   logic [3:0]       col_sel;
   logic [3:0]       row_sel;
   logic [3:0]       filas_nxt;

   always_comb begin
      state_nxt = state;
      contact   = 1'b0;
      case (state)
         IDLE: begin
            if (key_valid)
               state_nxt = NO_BOUNCE ? HOLD : BOUNCE_IN;
         end
         BOUNCE_IN: begin
            contact = ~bphase;
            if (cnt == BOUNCE_LAST)
               state_nxt = HOLD;
         end
         HOLD: begin
            contact = 1'b1;
            if (cnt == HOLD_LAST)
               state_nxt = NO_BOUNCE ? GAP : BOUNCE_OUT;
         end
         BOUNCE_OUT: begin
            contact = bphase;
            if (cnt == BOUNCE_LAST)
               state_nxt = GAP;
         end
         GAP: begin
            if (cnt == GAP_LAST)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // abort opens the contact on the very edge it is sampled
      if (abort && (state == BOUNCE_IN || state == HOLD || state == BOUNCE_OUT)) begin
         state_nxt = GAP;
         contact   = 1'b0;
      end
   end

   always_comb begin
      col_sel = 4'b0001;
      row_sel = 4'b0001;
      case (key_q)
         4'h0: begin col_sel = 4'b0001; row_sel = 4'b1000; end
         4'h1: begin col_sel = 4'b0100; row_sel = 4'b0001; end
         4'h2: begin col_sel = 4'b0001; row_sel = 4'b0001; end
         4'h3: begin col_sel = 4'b0010; row_sel = 4'b0001; end
         4'h4: begin col_sel = 4'b0100; row_sel = 4'b0010; end
         4'h5: begin col_sel = 4'b0001; row_sel = 4'b0010; end
         4'h6: begin col_sel = 4'b0010; row_sel = 4'b0010; end
         4'h7: begin col_sel = 4'b0100; row_sel = 4'b0100; end
         4'h8: begin col_sel = 4'b0001; row_sel = 4'b0100; end
         4'h9: begin col_sel = 4'b0010; row_sel = 4'b0100; end
         4'hA: begin col_sel = 4'b1000; row_sel = 4'b0001; end
         4'hB: begin col_sel = 4'b1000; row_sel = 4'b0010; end
         4'hC: begin col_sel = 4'b1000; row_sel = 4'b0100; end
         4'hD: begin col_sel = 4'b1000; row_sel = 4'b1000; end
         4'hE: begin col_sel = 4'b0100; row_sel = 4'b1000; end
         4'hF: begin col_sel = 4'b0010; row_sel = 4'b1000; end
         default: begin col_sel = 4'b0001; row_sel = 4'b0001; end
      endcase
   end

   // any set column bit of the key's column closes the path, as in the real matrix
   assign filas_nxt = (contact && |(columnas & col_sel)) ? ~row_sel : 4'b1111;
   assign key_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state  <= IDLE;
         cnt    <= '0;
         pcnt   <= '0;
         bphase <= 1'b0;
         key_q  <= 4'h0;
         filas  <= 4'b1111;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         filas <= filas_nxt;
         done  <= (state == GAP) && (state_nxt == IDLE);
         if (state == IDLE && key_valid)
            key_q <= key_code;
         if (state_nxt != state || state_nxt == IDLE) begin
            cnt    <= '0;
            pcnt   <= '0;
            bphase <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
            if (pcnt == PERIOD_LAST) begin
               pcnt   <= '0;
               bphase <= ~bphase;
            end else begin
               pcnt <= pcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Synthesizable model of the 4x4 membrane keypad, seen from the keypad side of the matrix. It receives the one-hot column strobes driven by the keypad scanner and drives the active-low row lines back.
- It presses one requested key code per transaction, with programmable contact bounce, hold time and release gap.
- Used for on-board self-test and for closed-loop regression of the scanner without a physical keypad.

Parameters:
- HOLD_CYCLES, 200000: cycles the contact stays solidly closed.
- BOUNCE_CYCLES, 2000: length of each bounce phase (press and release). 0 skips both bounce phases.
- BOUNCE_PERIOD, 100: cycles between contact toggles during a bounce phase. Must be ≥1.
- GAP_CYCLES, 50000: cycles the contact stays open after release, before `done` asserts.
- CNT_W, 24: phase counter width. Every cycle parameter must be < 2^CNT_W.

Ports:
- clk, in, 1: system clock.
- n_reset, in, 1: asynchronous, active-low reset.
- columnas, in, 4: column strobes from the scanner; bit set = column driven.
- key_code, in, 4: hex key to press.
- key_valid, in, 1: request strobe.
- key_ready, out, 1: emulator idle, request accepted on this cycle.
- abort, in, 1: force early release.
- filas, out, 4: row lines, active-low, 4'b1111 = no key.
- busy, out, 1: transaction in progress.
- done, out, 1: one-cycle pulse at transaction end.

Behaviour:
- Reset (async, n_reset=0):
  - State IDLE; filas=4'b1111, key_ready=1, busy=0, done=0.
  - Counters and latched key cleared; contact open.
  - Reset mid-transaction releases the key immediately.
- Key map (column bit, row bit pulled low):
  - col0: 2/r0, 5/r1, 8/r2, 0/r3.
  - col1: 3/r0, 6/r1, 9/r2, F/r3.
  - col2: 1/r0, 4/r1, 7/r2, E/r3.
  - col3: A/r0, B/r1, C/r2, D/r3.
- Handshake:
  - Accept on the rising edge where key_valid && key_ready.
  - key_code is latched on that edge; key_ready drops and busy rises on the same edge.
  - key_valid while busy is ignored; there is no queueing.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP. The phase counter is cleared on every state entry.
  - IDLE → BOUNCE_IN on accept, or → HOLD if BOUNCE_CYCLES=0.
  - BOUNCE_IN: contact starts closed and toggles every BOUNCE_PERIOD cycles. → HOLD after BOUNCE_CYCLES cycles.
  - HOLD: contact closed. → BOUNCE_OUT (or GAP if BOUNCE_CYCLES=0) after HOLD_CYCLES cycles.
  - BOUNCE_OUT: contact starts open and toggles every BOUNCE_PERIOD cycles. → GAP after BOUNCE_CYCLES cycles.
  - GAP: contact open. After GAP_CYCLES cycles: → IDLE, done=1 for exactly one cycle, key_ready=1, busy=0 on the same edge.
- abort=1 in BOUNCE_IN, HOLD or BOUNCE_OUT:
  - Next state is GAP with contact open; GAP still runs full length and done still pulses.
  - abort in IDLE or GAP has no effect.
- Row drive (registered, 1-cycle latency):
  - filas[r] <= 0 iff contact closed, columnas[col(key)]=1 and r=row(key); all other row bits <= 1.
  - Non-one-hot columnas (0000, multiple bits) follows the physical matrix: the row pulls low whenever the key's column bit is set.
  - A column change propagates to filas on the next edge.
- Counter does not wrap: each phase terminates at count = param-1.

Test Plan (sim parameters HOLD_CYCLES=20, BOUNCE_CYCLES=8, BOUNCE_PERIOD=2, GAP_CYCLES=5):
- Reset then idle → filas=1111, key_ready=1, busy=0, done=0. Assert n_reset=0 mid-HOLD → filas=1111 asynchronously, key_ready=1.
- Press key 5 with BOUNCE_CYCLES=0 and columnas=0001 constant:
  - filas=1101 for 20 cycles, starting one cycle after accept.
  - filas=1111 for the 5 GAP cycles, then a single done pulse, with key_ready=1 on the same edge.
- All 16 codes with columnas cycling 0001→0010→0100→1000 (one column per cycle) → filas low only in the mapped column/row. Examples: key E gives r3 low while columnas=0100; key A gives r0 low while columnas=1000.
- Bounce for key 1 with columnas=0100 held:
  - BOUNCE_IN: filas alternates 1110,1110,1111,1111 for 8 cycles.
  - HOLD: 1110 for 20 cycles.
  - BOUNCE_OUT: alternates starting 1111.
  - Total busy time = 8+20+8+5 = 41 cycles.
- key_valid held high during a transaction with a different code → ignored. The second key is accepted only on the cycle key_ready returns to 1.
- abort pulsed at HOLD cycle 3 → filas=1111 on the next edge, then GAP of 5 cycles, then done pulse.
